// File: rtl/mt19937_pkg.sv
// Shared MT19937 constants and the seeding FSM state encoding.
package mt19937_pkg;

  localparam int          MT_N       = 624;
  localparam int          MT_M       = 397;
  localparam int          MT_W       = 32;
  localparam logic [31:0] INIT_MULT  = 32'd1812433253;
  localparam int          INIT_SHIFT = 30;

  // Tempering masks and twist matrix constant used by the generator proper.
  localparam logic [31:0] TEMPER_B   = 32'h9d2c5680;
  localparam logic [31:0] TEMPER_C   = 32'hefc60000;
  localparam logic [31:0] TWIST_A    = 32'h9908b0df;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EMIT   = 2'd1,
    ST_FINISH = 2'd2
  } mt_state_e;

endpackage

// File: rtl/mt19937_seed_init_if.sv
// Word stream from the seeding engine into the generator's state loader.
interface mt19937_seed_init_if #(
  parameter int IDX_W = 10
) ();
  logic             word_valid;
  logic             word_ready;
  logic [31:0]      word_data;
  logic [IDX_W-1:0] word_index;

  modport master (output word_valid, output word_data, output word_index, input word_ready);
  modport slave  (input word_valid, input word_data, input word_index, output word_ready);
endinterface

// File: rtl/mt19937_init_step.sv
// Purely combinational seeding recurrence: y = MULT*(x ^ (x >> SHIFT)) + i, mod 2^32.
// Product is kept at 32 bits; the index is zero-extended before the add.
module mt19937_init_step #(
  parameter logic [31:0] MULT  = 32'd1812433253,
  parameter int          SHIFT = 30,
  parameter int          IDX_W = 10
) (
  input  logic [31:0]      x,
  input  logic [IDX_W-1:0] i,
  output logic [31:0]      y
);
  logic [31:0] mix;
  logic [31:0] prod;

  assign mix  = x ^ (x >> SHIFT);
  assign prod = MULT * mix;
  assign y    = prod + 32'(i);
endmodule

// File: rtl/mt19937_seed_init.sv
// Expands a 32-bit seed into NUM_WORDS MT19937 state words; 1 cycle start-to-first-word.
// Words held stable under word_ready=0. MT19937_SEED_INIT_PIPE_EN registers the step
// output, adding one bubble per word (1 word / 2 cycles).
module mt19937_seed_init
  import mt19937_pkg::*;
#(
  parameter int          NUM_WORDS = MT_N,
  parameter logic [31:0] MULT      = INIT_MULT,
  parameter int          SHIFT     = INIT_SHIFT,
  parameter int          IDX_W     = $clog2(NUM_WORDS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [31:0]                 seed,
  output logic                        busy,
  output logic                        done,
  mt19937_seed_init_if.master         word_if
);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  mt_state_e        state_q, state_d;
  logic [31:0]      data_q;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_nxt;
  logic [31:0]      step_y;
  logic             bubble;
  logic             hs;
  logic             last;

  assign idx_nxt = idx_q + IDX_W'(1);

  mt19937_init_step #(
    .MULT  (MULT),
    .SHIFT (SHIFT),
    .IDX_W (IDX_W)
  ) u_step (
    .x (data_q),
    .i (idx_nxt),
    .y (step_y)
  );

  assign word_if.word_valid = (state_q == ST_EMIT) && !bubble;
  assign word_if.word_data  = data_q;
  assign word_if.word_index = idx_q;
  assign busy = (state_q == ST_EMIT);
  assign done = (state_q == ST_FINISH);
  assign hs   = word_if.word_valid && word_if.word_ready;
  assign last = (idx_q == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_EMIT;
      ST_EMIT:   if (hs && last) state_d = ST_FINISH;
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

`ifdef MT19937_SEED_INIT_PIPE_EN
  logic        bubble_q;
  logic [31:0] step_q;

  assign bubble = bubble_q;

  // The step result is captured at the handshake and becomes the visible word one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q   <= '0;
      idx_q    <= '0;
      bubble_q <= 1'b0;
      step_q   <= '0;
    end else if (state_q == ST_IDLE && start) begin
      data_q   <= seed;
      idx_q    <= '0;
      bubble_q <= 1'b0;
    end else if (bubble_q) begin
      data_q   <= step_q;
      bubble_q <= 1'b0;
    end else if (hs && !last) begin
      step_q   <= step_y;
      idx_q    <= idx_nxt;
      bubble_q <= 1'b1;
    end
  end
`else
  assign bubble = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      idx_q  <= '0;
    end else if (state_q == ST_IDLE && start) begin
      data_q <= seed;
      idx_q  <= '0;
    end else if (hs && !last) begin
      data_q <= step_y;
      idx_q  <= idx_nxt;
    end
  end
`endif

endmodule

// File: doc/mt19937_seed_init.md
Name: mt19937_seed_init

Overview:
- Upstream seeding engine for the mt19937 generator.
- Expands a 32-bit seed into the full NUM_WORDS-word state using the standard MT19937 recurrence: x[0]=seed, x[i]=MULT*(x[i-1]^(x[i-1]>>SHIFT))+i, mod 2^32.
- Streams words one at a time over a valid/ready interface into the generator's state loader.
- Replaces the all-zero reset state of the generator, which is degenerate.

Parameters:
- NUM_WORDS, 624, number of 32-bit state words produced per seeding.
- MULT, 32'd1812433253, recurrence multiplier.
- SHIFT, 30, right-shift amount in the recurrence.
- IDX_W, $clog2(NUM_WORDS), width of the word index.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin seeding; sampled only in IDLE.
- seed  in  32  seed value, captured on the accepted start.
- busy  out  1  high from the accepted start until the last word is accepted.
- done  out  1  one-cycle pulse on the cycle after the last word handshake.
- word_valid  out  1  word_data and word_index are valid.
- word_ready  in  1  downstream accepts the word this cycle.
- word_data  out  32  current state word x[i].
- word_index  out  IDX_W  index i of word_data, from 0 to NUM_WORDS-1.

Behaviour:
- Reset: state=IDLE; busy=0, done=0, word_valid=0, word_data=0, word_index=0. Reset takes priority over every other input in any state. A reset mid-stream aborts it immediately; no further words are emitted and done does not pulse.
- FSM states: IDLE, EMIT, FINISH.
- IDLE:
  - start=1 captures the seed, sets word_data=seed and word_index=0, and moves to EMIT.
  - word_valid and busy go high on the next cycle, so latency is 1 cycle from start to the first valid word.
- EMIT:
  - word_valid=1.
  - On a handshake (word_valid & word_ready) with word_index<NUM_WORDS-1: word_data <= step(word_data, word_index+1) and word_index increments. The new word is valid the following cycle, giving a throughput of 1 word per cycle under constant ready.
  - On a handshake with word_index==NUM_WORDS-1: move to FINISH; word_valid drops the next cycle.
  - With word_ready=0, word_data, word_index and word_valid are held stable. word_valid is never retracted without a handshake.
- FINISH: done=1 and busy=0 for exactly one cycle, then IDLE.
- start is ignored outside IDLE, including the cycle done is high.
- Arithmetic:
  - step(x,i) = low 32 bits of MULT*(x ^ (x>>SHIFT)) + i.
  - The addend i is zero-extended from IDX_W to 32 bits.
  - The 64-bit product is never formed; the product is truncated to 32 bits before the add.
  - All wrap-around is modulo 2^32.
- Index never exceeds NUM_WORDS-1 and does not wrap within one seeding.

Optional Feature:
- Macro: MT19937_SEED_INIT_PIPE_EN.
- Defined:
  - A register is inserted after the multiplier to ease timing.
  - After each handshake, word_valid is low for one bubble cycle while the product settles.
  - Throughput is 1 word per 2 cycles; latency from start to the first word stays at 1.
  - Hold rules are unchanged.
- Undefined: single-cycle combinational step, as described under Behaviour.

Decomposition:
- Package mt19937_pkg holds:
  - MT_N=624, MT_M=397, MT_W=32.
  - INIT_MULT=1812433253, INIT_SHIFT=30.
  - The tempering constants 32'h9d2c5680 and 32'hefc60000 and the twist constant 32'h9908b0df, shared with the generator.
  - The FSM state encoding typedef.
- One sub-module, mt19937_init_step, is purely combinational: (x, i) -> step(x, i).
- The optional pipeline register lives in the parent, not in mt19937_init_step.

Test Plan:
- Seed 0, word_ready=1 constantly -> words 0:0, 1:1, 2:0x6C078967; exactly 624 handshakes; done pulses once, 1 cycle after index 623 is accepted.
- Seed 5489, word_ready=1 -> word0=5489, word1=1301868182; the full stream matches a C reference model word-for-word.
- Seed 5489 with random word_ready backpressure (about 50%) -> word_data and word_index stable while stalled; the sequence is identical to the previous test.
- start pulsed mid-stream with seed 0xFFFFFFFF -> ignored; the stream continues with the original seed.
- rst asserted at word_index 300 -> next cycle all outputs are 0 and state is IDLE; a fresh start with seed 1 restarts from index 0 with word0=1.
- With MT19937_SEED_INIT_PIPE_EN and word_ready=1 -> one valid word every 2 cycles; total 1248 cycles plus 1 for start-to-first-word; data identical to the non-pipelined run.
